// File: rtl/led_scroll_ctrl.sv
// led_scroll_ctrl
// Scrolls a 4-character window through a 16-entry message of 4-bit character
// codes and drives the four digit codes of the seven-segment anode multiplexer.
// Code 12 is the decoder's blank code and is shown whenever the display is dark.
//
// Build option: define LED_SCROLL_DIR_EN to add the 'dir' input, which selects
// reverse scrolling (pos decrements, wrapping 0 -> L-1) when high.
`timescale 1ns/1ps
module led_scroll_ctrl #(
  parameter int unsigned STEP_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [3:0] msg_len,
  input  logic       start,
  input  logic       stop,
`ifdef LED_SCROLL_DIR_EN
  input  logic       dir,
`endif
  output logic       busy,
  output logic       wrap,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0
);

  localparam int unsigned      DIV_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [3:0]       BLANK    = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       mem [16];
  logic [3:0]       pos_q;
  logic [3:0]       len_q;
  logic [DIV_W-1:0] div_q;
  logic             start_go;
  logic             step;
  logic             at_wrap;
  logic [3:0]       pos_step;
  logic [3:0]       idx1;
  logic [3:0]       idx2;
  logic [3:0]       idx3;

  assign busy = (state_q == RUN);

  // A step fires on the last divider count; stop in the same cycle cancels it.
  assign step = (state_q == RUN) && (div_q == DIV_LAST) && !stop;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop has priority over start.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d  = state_q;
    start_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = RUN;
          start_go = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next window position for a step and whether that step wraps.
  always_comb begin
    pos_step = (pos_q == len_q) ? 4'd0 : pos_q + 4'd1;
    at_wrap  = (pos_q == len_q);
`ifdef LED_SCROLL_DIR_EN
    if (dir) begin
      pos_step = (pos_q == 4'd0) ? len_q : pos_q - 4'd1;
      at_wrap  = (pos_q == 4'd0);
    end
`endif
  end

  // Window indices: each one is the previous plus one, wrapping at L-1, which
  // gives true modulo-L even when L < 4 (L=1 repeats entry 0 four times).
  always_comb begin
    idx1 = (pos_q == len_q) ? 4'd0 : pos_q + 4'd1;
    idx2 = (idx1  == len_q) ? 4'd0 : idx1  + 4'd1;
    idx3 = (idx2  == len_q) ? 4'd0 : idx2  + 4'd1;
  end

  // Position, step divider, latched length and registered wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q <= 4'd0;
      div_q <= '0;
      len_q <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      wrap <= step && at_wrap;
      if (start_go) begin
        pos_q <= 4'd0;
        div_q <= '0;
        len_q <= msg_len;
      end else if (state_q == RUN) begin
        if (stop) begin
          pos_q <= 4'd0;
          div_q <= '0;
        end else if (step) begin
          pos_q <= pos_step;
          div_q <= '0;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  // Message storage; writes are accepted in any state.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the message array is reset to blank on purpose, so it is built
    // from flip-flops rather than a RAM macro (RAMs cannot be reset).
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= BLANK;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered digit codes: current window while running, blank otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char3 <= BLANK;
      char2 <= BLANK;
      char1 <= BLANK;
      char0 <= BLANK;
    end else if (state_q == RUN) begin
      char3 <= mem[pos_q];
      char2 <= mem[idx1];
      char1 <= mem[idx2];
      char0 <= mem[idx3];
    end else begin
      char3 <= BLANK;
      char2 <= BLANK;
      char1 <= BLANK;
      char0 <= BLANK;
    end
  end

endmodule

// File: doc/led_scroll_ctrl.md
# led_scroll_ctrl

Message scroll controller for the 4-digit seven-segment display. Holds a 16-entry message of 4-bit character codes, and drives the four digit codes `char3..char0` into the anode multiplexer. While running, it advances a 4-character window through the message at a fixed clock-divided rate, wrapping at the programmed length. Code 12 is the decoder's blank code and is used whenever the display must be dark.

## Interface
- `STEP_DIV`, default 16: number of `clk` cycles per scroll step; legal range 2..65535.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  message write strobe.
- `wr_addr`  in  4  message entry index, 0..15.
- `wr_data`  in  4  character code to write.
- `msg_len`  in  4  message length minus 1; effective length L = `msg_len`+1, range 1..16.
- `start`  in  1  level, sampled each cycle; begins scrolling from IDLE.
- `stop`  in  1  level, sampled each cycle; returns to IDLE.
- `busy`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse when the window position wraps.
- `char3`, `char2`, `char1`, `char0`  out  4 each  digit codes; `char3` is the leftmost digit.

## Operation
- Storage: `mem[0..15]`, 4 bits each; reset value 12 for every entry.
  - When `wr_en`=1, `mem[wr_addr]` ← `wr_data` on the clock edge.
  - Writes are accepted in any state.
- Registers:
  - `state` ∈ {IDLE, RUN}.
  - `pos`: 4 bits.
  - `div`: counter of width ceil(log2(STEP_DIV)).
  - `len_q`: 4 bits, the latched `msg_len`.
- IDLE:
  - `busy`=0; all `char*` registered to 12.
  - If `start`=1 and `stop`=0: go to RUN with `pos`←0, `div`←0, `len_q`←`msg_len`.
- RUN:
  - `busy`=1.
  - `div` counts 0..STEP_DIV-1. At `div`=STEP_DIV-1, `div`←0 and `pos`←(`pos`+1) mod L.
  - `wrap`=1 for exactly the cycle after `pos` is updated from L-1 to 0.
  - Each cycle, `char3`←`mem[pos mod L]`, `char2`←`mem[(pos+1) mod L]`, `char1`←`mem[(pos+2) mod L]`, `char0`←`mem[(pos+3) mod L]`. The modulo is true modulo, including when L<4 (for L=1 all four digits show `mem[0]`).
  - `stop`=1: go to IDLE, `pos`←0, `div`←0.
  - `start` in RUN is ignored.
- Priority: `stop` beats `start` when both are asserted in the same cycle.
- `msg_len` is latched only at start. Changes to `msg_len` during RUN have no effect until the next start.
- A write to an entry currently inside the window appears on the outputs one cycle after the write edge.

## Timing
- Reset (asynchronous, immediate): `state`=IDLE, `pos`=0, `div`=0, `len_q`=0, `busy`=0, `wrap`=0, all `char*`=12, all `mem` entries=12.
- Start latency:
  - `start` sampled at edge E → `busy`=1 after E.
  - First window (`pos`=0) on `char*` after edge E+1.
- Step cadence: the window changes every STEP_DIV cycles, with `char*` updated one cycle after `pos`.
- Stop latency:
  - `stop` sampled at edge E → `busy`=0 after E.
  - `char*`=12 after edge E+1.
- `wrap` is registered, one cycle wide, and asserted only in RUN.
- Reset asserted mid-run aborts immediately. No step or write completes on the edge where `reset` is low.

## Configuration
- `LED_SCROLL_DIR_EN` defined:
  - Adds input `dir` (1 bit) to the port list, sampled each step.
  - `dir`=0: `pos` increments.
  - `dir`=1: `pos`←(`pos`-1) mod L, so 0→L-1; `wrap` pulses on the 0→L-1 transition.
- `LED_SCROLL_DIR_EN` undefined: `dir` port is absent and scrolling is increment-only.

## Test plan
- Load `mem[0..5]`=1,2,3,4,5,6; `msg_len`=5; STEP_DIV=4; pulse `start` → chars 1,2,3,4; 4 cycles later 2,3,4,5; at `pos`=4 chars 5,6,1,2; `wrap` pulses once every 24 cycles.
- `msg_len`=1, `mem[0]`=7, `mem[1]`=8, start → chars 7,8,7,8, then 8,7,8,7, alternating every STEP_DIV cycles.
- `start` and `stop` both high in IDLE → `busy` stays 0 and chars stay 12. `stop` mid-run → chars 12 two edges after `stop` is sampled; a new start resumes from `pos`=0.
- During RUN, write `mem[pos+1]`=9 → `char2`=9 on the cycle after the write edge. Change `msg_len` during RUN → wrap period unchanged.
- Drop `reset` mid-step → all outputs go to reset values without a clock. After release, chars stay 12 until `start`.
- With `LED_SCROLL_DIR_EN`, `dir`=1, L=6 → `pos` sequence 0,5,4,…; `wrap` pulses on the 0→5 transition.
